// File: rtl/sw_drv_pkg.sv
// Shared types and constants for the switch stimulus driver: phase encoding,
// the directed pattern table and the Galois LFSR step.
package sw_drv_pkg;

  typedef enum logic [1:0] {
    PH_IDLE     = 2'd0,
    PH_DIRECTED = 2'd1,
    PH_RANDOM   = 2'd2,
    PH_DONE     = 2'd3
  } phase_e;

  localparam int DIR_LEN = 8;

  localparam logic [31:0] DIR_TABLE [DIR_LEN] = '{
    32'h0000_0000, 32'h0000_0001, 32'h0000_00FF, 32'h0000_FFFF,
    32'h8000_0000, 32'hFFFF_FFFF, 32'h5555_5555, 32'hAAAA_AAAA
  };

  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  // Right-shifting Galois step; the mask keeps bit 31 set on feedback, so a
  // non-zero state can never collapse to zero.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_MASK : 32'h0);
  endfunction

endpackage

// File: rtl/sw_drv_lfsr32.sv
// 32-bit Galois LFSR: loads SEED on reset, advances one step when i_en is high.
module sw_drv_lfsr32
  import sw_drv_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_en,
  output logic [31:0] o_state
);

  logic [31:0] r_state;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= SEED;
    else if (i_en) r_state <= lfsr_next(r_state);
  end

  assign o_state = r_state;

endmodule

// File: rtl/sw_stim_driver.sv
// Switch stimulus sequencer: start delay, directed table sweep, optional LFSR
// phase (compiled in with SW_DRV_LFSR_EN), then parks in DONE until reset.
module sw_stim_driver
  import sw_drv_pkg::*;
#(
  parameter int          START_DELAY = 8,
  parameter int          HOLD_CYCLES = 256,
  parameter int          RAND_STEPS  = 16,
  parameter logic [31:0] LFSR_SEED   = 32'hACE1_2468
) (
  input  logic        i_clk,
  input  logic        i_reset,
  output logic [31:0] o_sw_data,
  output logic        o_sw_strobe,
  output logic [1:0]  o_phase,
  output logic        o_seq_done
);

  localparam int DW = (START_DELAY > 0) ? $clog2(START_DELAY + 1) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [DW-1:0] DELAY_LAST = DW'(START_DELAY);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);

  phase_e         r_phase;
  logic [2:0]     r_index;
  logic [HW-1:0]  r_hold;
  logic [DW-1:0]  r_delay;
  logic [31:0]    r_sw_data;
  logic           r_strobe;
  logic           r_done;
  logic           w_hold_tc;

  assign w_hold_tc = (r_hold == HOLD_LAST);

`ifdef SW_DRV_LFSR_EN
  localparam int RW = (RAND_STEPS > 1) ? $clog2(RAND_STEPS) : 1;
  localparam logic [RW-1:0] RAND_LAST = RW'((RAND_STEPS > 0) ? RAND_STEPS - 1 : 0);
  localparam logic [31:0]   SEED_EFF  = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;

  logic [RW-1:0] r_rstep;
  logic [31:0]   w_lfsr_state;
  logic          w_lfsr_adv;

  // The LFSR steps on the same edge its successor is loaded onto o_sw_data,
  // so the register and the output stay in lockstep.
  assign w_lfsr_adv = w_hold_tc &&
    (((r_phase == PH_DIRECTED) && (r_index == 3'd7) && (RAND_STEPS > 0)) ||
     ((r_phase == PH_RANDOM) && (r_rstep != RAND_LAST)));

  sw_drv_lfsr32 #(.SEED(SEED_EFF)) u_lfsr (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (w_lfsr_adv),
    .o_state (w_lfsr_state)
  );
`endif

  // NOTE: state uses non-blocking assignments so every branch reads the
  // pre-edge values; r_strobe is defaulted low so it pulses for one cycle only.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_phase   <= PH_IDLE;
      r_index   <= '0;
      r_hold    <= '0;
      r_delay   <= '0;
      r_sw_data <= '0;
      r_strobe  <= 1'b0;
      r_done    <= 1'b0;
`ifdef SW_DRV_LFSR_EN
      r_rstep   <= '0;
`endif
    end else begin
      r_strobe <= 1'b0;
      case (r_phase)
        PH_IDLE: begin
          if (r_delay == DELAY_LAST) begin
            r_phase   <= PH_DIRECTED;
            r_sw_data <= DIR_TABLE[0];
            r_strobe  <= 1'b1;
            r_hold    <= '0;
          end else begin
            r_delay <= r_delay + 1'b1;
          end
        end
        PH_DIRECTED: begin
          if (!w_hold_tc) begin
            r_hold <= r_hold + 1'b1;
          end else begin
            r_hold <= '0;
            if (r_index != 3'd7) begin
              r_index   <= r_index + 3'd1;
              r_sw_data <= DIR_TABLE[r_index + 3'd1];
              r_strobe  <= 1'b1;
            end
`ifdef SW_DRV_LFSR_EN
            else if (RAND_STEPS > 0) begin
              r_phase   <= PH_RANDOM;
              r_sw_data <= lfsr_next(w_lfsr_state);
              r_strobe  <= 1'b1;
            end
`endif
            else begin
              r_phase <= PH_DONE;
              r_done  <= 1'b1;
            end
          end
        end
`ifdef SW_DRV_LFSR_EN
        PH_RANDOM: begin
          if (!w_hold_tc) begin
            r_hold <= r_hold + 1'b1;
          end else if (r_rstep != RAND_LAST) begin
            r_hold    <= '0;
            r_rstep   <= r_rstep + 1'b1;
            r_sw_data <= lfsr_next(w_lfsr_state);
            r_strobe  <= 1'b1;
          end else begin
            r_phase <= PH_DONE;
            r_done  <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign o_sw_data   = r_sw_data;
  assign o_sw_strobe = r_strobe;
  assign o_phase     = r_phase;
  assign o_seq_done  = r_done;

endmodule

// File: tb/tb_sw_stim_driver.sv
// Bench for sw_stim_driver: two configurations against a cycle-indexed model of
// the stimulus schedule, with randomized synchronous/asynchronous reset timing.
module tb_sw_stim_driver;

  localparam logic [31:0] EXP_TAB [8] = '{
    32'h0000_0000, 32'h0000_0001, 32'h0000_00FF, 32'h0000_FFFF,
    32'h8000_0000, 32'hFFFF_FFFF, 32'h5555_5555, 32'hAAAA_AAAA
  };

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] a_data, b_data;
  logic        a_strobe, b_strobe, a_done, b_done;
  logic [1:0]  a_phase, b_phase;

  sw_stim_driver #(.START_DELAY(8), .HOLD_CYCLES(4), .RAND_STEPS(2), .LFSR_SEED(32'h1)) u_a (
    .i_clk(clk), .i_reset(rst), .o_sw_data(a_data), .o_sw_strobe(a_strobe),
    .o_phase(a_phase), .o_seq_done(a_done));

  sw_stim_driver #(.START_DELAY(0), .HOLD_CYCLES(1), .RAND_STEPS(3), .LFSR_SEED(32'h0)) u_b (
    .i_clk(clk), .i_reset(rst), .o_sw_data(b_data), .o_sw_strobe(b_strobe),
    .o_phase(b_phase), .o_seq_done(b_done));

  int vectors = 0;
  int miscompares = 0;
  int k = 0;  // rising edges seen since reset was released

  always @(posedge clk or posedge rst) begin
    if (rst) k <= 0;
    else     k <= k + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at t=%0t k=%0d: got %h expected %h", name, $time, k, act, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    logic [31:0] n;
    n = {1'b0, s[31:1]};
    if (s[0]) n = n ^ 32'h8020_0003;
    return n;
  endfunction

  // Expected outputs after k edges out of reset, from the schedule:
  // sd idle edges, 8 directed values x h, re random values x h, then DONE.
  function automatic void model(input int kk, input int sd, input int h, input int r,
                                input logic [31:0] seed, output logic [31:0] d,
                                output logic st, output logic [1:0] ph, output logic dn);
    int j;
    int re;
    logic [31:0] s;
`ifdef SW_DRV_LFSR_EN
    re = r;
`else
    re = 0 * r;
`endif
    d = 32'h0; st = 1'b0; ph = 2'd0; dn = 1'b0;
    if (kk <= sd) return;
    j = kk - sd - 1;
    if (j < 8 * h) begin
      d = EXP_TAB[j / h]; st = (j % h == 0); ph = 2'd1;
      return;
    end
    j = j - 8 * h;
    s = (seed == 32'h0) ? 32'h1 : seed;
    if (j < re * h) begin
      for (int n = 0; n <= j / h; n++) s = lfsr_step(s);
      d = s; st = (j % h == 0); ph = 2'd2;
      return;
    end
    d = EXP_TAB[7];
    if (re > 0) begin
      for (int n = 0; n < re; n++) s = lfsr_step(s);
      d = s;
    end
    ph = 2'd3; dn = 1'b1;
  endfunction

  always @(negedge clk) begin
    logic [31:0] d;
    logic st, dn;
    logic [1:0] ph;
    model(k, 8, 4, 2, 32'h1, d, st, ph, dn);
    check("a_data", a_data, d);
    check("a_strobe", 32'(a_strobe), 32'(st));
    check("a_phase", 32'(a_phase), 32'(ph));
    check("a_done", 32'(a_done), 32'(dn));
    model(k, 0, 1, 3, 32'h0, d, st, ph, dn);
    check("b_data", b_data, d);
    check("b_strobe", 32'(b_strobe), 32'(st));
    check("b_phase", 32'(b_phase), 32'(ph));
    check("b_done", 32'(b_done), 32'(dn));
  end

  task automatic wait_k(input int target);
    for (int i = 0; i < 500 && k < target; i++) @(negedge clk);
    check("wait_k", k, target);
  endtask

  initial begin
    int strobes;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_data", a_data, 32'h0);
    check("reset_phase", 32'(a_phase), 32'd0);
    rst = 1'b0;

    // Hand-computed pins of the schedule.
    strobes = 0;
    for (int e = 1; e <= 9; e++) begin
      @(negedge clk);
      if (e <= 8) strobes += int'(b_strobe);
      if (e == 8) begin
        check("a_idle_k8_phase", 32'(a_phase), 32'd0);
        check("a_idle_k8_strobe", 32'(a_strobe), 32'd0);
        check("b_k8_data", b_data, 32'hAAAA_AAAA);
      end
    end
    check("b_strobe_run", strobes, 8);
    check("a_k9_strobe", 32'(a_strobe), 32'd1);
    check("a_k9_phase", 32'(a_phase), 32'd1);
    check("a_k9_data", a_data, 32'h0);
`ifdef SW_DRV_LFSR_EN
    check("b_k9_phase", 32'(b_phase), 32'd2);
    check("b_k9_data", b_data, 32'h8020_0003);
`else
    check("b_k9_phase", 32'(b_phase), 32'd3);
    check("b_k9_done", 32'(b_done), 32'd1);
    check("b_k9_data", b_data, 32'hAAAA_AAAA);
`endif
    strobes = 1;
    for (int e = 10; e <= 40; e++) begin
      @(negedge clk);
      strobes += int'(a_strobe);
      if (e == 29) check("a_k29_data", a_data, 32'hFFFF_FFFF);
      if (e == 40) check("a_k40_data", a_data, 32'hAAAA_AAAA);
    end
    check("a_directed_strobes", strobes, 8);
    @(negedge clk);
`ifdef SW_DRV_LFSR_EN
    check("a_k41_phase", 32'(a_phase), 32'd2);
    check("a_k41_data", a_data, 32'h8020_0003);
`else
    check("a_k41_phase", 32'(a_phase), 32'd3);
    check("a_k41_data", a_data, 32'hAAAA_AAAA);
    check("a_k41_done", 32'(a_done), 32'd1);
`endif

    // Asynchronous reset in the middle of index 5's hold.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_k(30);
    check("a_idx5_data", a_data, 32'hFFFF_FFFF);
    #2 rst = 1'b1;
    #1;
    check("async_a_data", a_data, 32'h0);
    check("async_a_phase", 32'(a_phase), 32'd0);
    check("async_b_data", b_data, 32'h0);
    check("async_b_done", 32'(b_done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_k(9);
    check("restart_a_strobe", 32'(a_strobe), 32'd1);

    // Randomized reset intervals; the compare process checks every cycle.
    for (int it = 0; it < 25; it++) begin
      repeat ($urandom_range(70, 1)) @(negedge clk);
      #($urandom_range(4, 1));
      rst = 1'b1;
      repeat ($urandom_range(3, 1)) @(negedge clk);
      rst = 1'b0;
    end
    repeat (60) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
